// File: rtl/spi_memory_slave_if.sv
// SPI-side signal bundle between the pin conditioners / pin buffer and the memory slave.
interface spi_memory_slave_if;
   logic cs_cond;
   logic mosi_cond;
   logic sclk_pos;
   logic sclk_neg;
   logic miso;
   logic miso_oe;
   logic wr_strobe;
   logic frame_abort;

   modport slave (
      input  cs_cond, mosi_cond, sclk_pos, sclk_neg,
      output miso, miso_oe, wr_strobe, frame_abort
   );

   modport master (
      output cs_cond, mosi_cond, sclk_pos, sclk_neg,
      input  miso, miso_oe, wr_strobe, frame_abort
   );
endinterface

// File: rtl/spi_memory_slave.sv
// SPI memory slave: 16-bit frames {addr, R/W, data} into a byte memory.
// Runs entirely on clk; SCLK arrives as one-cycle edge pulses.
module spi_memory_slave #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   spi_memory_slave_if.slave    bus
);

   localparam int MAXB  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int CNT_W = $clog2(MAXB + 2);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [CNT_W-1:0] CNT_RW   = CNT_W'(ADDR_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {IDLE, ADDR, READ, WRITE, DONE} state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   // Only the first DATA_W-1 data bits need storing; the last one is taken
   // straight from mosi_cond in the commit cycle.
   logic [DATA_W-2:0]   rx_q, rx_d;
   logic [DATA_W-1:0]   tx_q, tx_d;
   logic                miso_q, miso_d;
   logic                oe_q, oe_d;
   logic                wr_q, wr_d;
   logic                abort_q, abort_d;
   logic                mem_we;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic cs, mosi, pos, neg;
   assign cs   = bus.cs_cond;
   assign mosi = bus.mosi_cond;
   assign pos  = bus.sclk_pos;
   // A simultaneous rising edge wins; the falling edge is dropped.
   assign neg  = bus.sclk_neg & ~bus.sclk_pos;

   assign mem_wdata = {rx_q, mosi};

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         rx_q    <= '0;
         tx_q    <= '0;
         miso_q  <= 1'b0;
         oe_q    <= 1'b0;
         wr_q    <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         rx_q    <= rx_d;
         tx_q    <= tx_d;
         miso_q  <= miso_d;
         oe_q    <= oe_d;
         wr_q    <= wr_d;
         abort_q <= abort_d;
      end
   end

   // Next state and shift-register datapath; CS high outside IDLE overrides any edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      rx_d    = rx_q;
      tx_d    = tx_q;
      if (state_q == IDLE) begin
         if (!cs) begin
            state_d = ADDR;
            cnt_d   = '0;
         end
      end else if (cs) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ADDR: if (pos) begin
               if (cnt_q == CNT_RW) begin
                  // R/W bit: address is already complete, do not shift it.
                  cnt_d = '0;
                  if (mosi) begin
                     state_d = READ;
                     tx_d    = mem_q[addr_q];
                  end else begin
                     state_d = WRITE;
                  end
               end else begin
                  addr_d = {addr_q[ADDR_W-2:0], mosi};
                  cnt_d  = cnt_q + CNT_ONE;
               end
            end
            READ: if (neg) begin
               tx_d  = {tx_q[DATA_W-2:0], 1'b0};
               cnt_d = cnt_q + CNT_ONE;
               if (cnt_q == CNT_LAST) state_d = DONE;
            end
            WRITE: if (pos) begin
               rx_d  = {rx_q[DATA_W-3:0], mosi};
               cnt_d = cnt_q + CNT_ONE;
               if (cnt_q == CNT_LAST) state_d = DONE;
            end
            default: ;
         endcase
      end
   end

   // Output decode: MISO shift, tristate enable, write commit, abort pulse.
   always_comb begin
      miso_d  = miso_q;
      oe_d    = (state_d == READ) || ((state_d == DONE) && oe_q);
      wr_d    = 1'b0;
      mem_we  = 1'b0;
      abort_d = cs && (state_q inside {ADDR, READ, WRITE});
      if (!cs && state_q == READ && neg)
         miso_d = tx_q[DATA_W-1];
      if (!cs && state_q == WRITE && pos && cnt_q == CNT_LAST) begin
         mem_we = 1'b1;
         wr_d   = 1'b1;
      end
   end

   // Byte memory, cleared by reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (mem_we) begin
         mem_q[addr_q] <= mem_wdata;
      end
   end

   assign bus.miso        = miso_q;
   assign bus.miso_oe     = oe_q;
   assign bus.wr_strobe   = wr_q;
   assign bus.frame_abort = abort_q;

endmodule

// File: tb/tb_spi_memory_slave.sv
// Directed bench for spi_memory_slave: frame table plus reset/abort/collision sequences.
module tb_spi_memory_slave;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #10 clk = ~clk;

   spi_memory_slave_if bus ();

   spi_memory_slave #(.ADDR_W(7), .DATA_W(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int   tests = 0;
   int   fails = 0;
   int   wr_cnt = 0;
   int   ab_cnt = 0;
   int   oe_err = 0;
   logic exp_oe = 1'b0;

   typedef struct {
      logic [6:0] addr;
      logic       rw;
      logic [7:0] data;
      int         nbits;
      logic [7:0] exp_rd;
      int         exp_wr;
   } vec_t;

   vec_t tbl [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One clk cycle: inputs applied at negedge, outputs observed 1ns after posedge.
   task automatic drive(input logic cs, input logic mosi, input logic pos, input logic neg);
      @(negedge clk);
      bus.cs_cond   = cs;
      bus.mosi_cond = mosi;
      bus.sclk_pos  = pos;
      bus.sclk_neg  = neg;
      @(posedge clk);
      #1;
      wr_cnt += int'(bus.wr_strobe);
      ab_cnt += int'(bus.frame_abort);
      if (bus.miso_oe !== exp_oe) oe_err++;
   endtask

   // Full or partial frame; each SCLK period is pos, gap, neg, gap.
   task automatic frame(input logic [6:0] addr, input logic rw, input logic [7:0] data,
                        input int nbits, input int collide, input bit end_cs,
                        output logic [7:0] rd);
      logic [15:0] s;
      logic        b;
      s  = {addr, rw, data};
      rd = '0;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < nbits; i++) begin
         b = (i < 16) ? s[15-i] : 1'b1;
         if (rw && i == 7) exp_oe = 1'b1;
         drive(1'b0, b, 1'b1, (i == collide));
         drive(1'b0, b, 1'b0, 1'b0);
         drive(1'b0, b, 1'b0, 1'b1);
         if (rw && i >= 7 && i <= 14) rd = {rd[6:0], bus.miso};
         drive(1'b0, b, 1'b0, 1'b0);
      end
      if (end_cs) begin
         exp_oe = 1'b0;
         drive(1'b1, 1'b0, 1'b0, 1'b0);
         drive(1'b1, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic read_check(input string name, input logic [6:0] addr, input int collide,
                             input logic [7:0] exp);
      logic [7:0] rd;
      oe_err = 0;
      frame(addr, 1'b1, 8'h00, 16, collide, 1'b1, rd);
      check(name, rd, exp);
      check({name, "_oe"}, oe_err, 0);
   endtask

   initial begin
      logic [7:0] rd;
      int         w0, a0;

      tbl[0] = '{7'h15, 1'b0, 8'hA5, 16, 8'h00, 1};
      tbl[1] = '{7'h15, 1'b1, 8'h00, 16, 8'hA5, 0};
      tbl[2] = '{7'h01, 1'b0, 8'h3C, 20, 8'h00, 1};
      tbl[3] = '{7'h01, 1'b1, 8'h00, 16, 8'h3C, 0};
      tbl[4] = '{7'h00, 1'b0, 8'hFF, 16, 8'h00, 1};
      tbl[5] = '{7'h7F, 1'b0, 8'h11, 16, 8'h00, 1};
      tbl[6] = '{7'h00, 1'b1, 8'h00, 16, 8'hFF, 0};
      tbl[7] = '{7'h7F, 1'b1, 8'h00, 16, 8'h11, 0};
      tbl[8] = '{7'h02, 1'b1, 8'h00, 16, 8'h00, 0};
      tbl[9] = '{7'h15, 1'b1, 8'h00, 16, 8'hA5, 0};

      bus.cs_cond   = 1'b1;
      bus.mosi_cond = 1'b0;
      bus.sclk_pos  = 1'b0;
      bus.sclk_neg  = 1'b0;

      // Reset state.
      repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0);
      check("reset_outs", {bus.miso, bus.miso_oe, bus.wr_strobe, bus.frame_abort}, 4'h0);
      reset_n = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 1'b0);

      // Table of complete frames.
      for (int k = 0; k < 10; k++) begin
         w0 = wr_cnt;
         a0 = ab_cnt;
         oe_err = 0;
         frame(tbl[k].addr, tbl[k].rw, tbl[k].data, tbl[k].nbits, -1, 1'b1, rd);
         if (tbl[k].rw) check($sformatf("v%0d_rdata", k), rd, tbl[k].exp_rd);
         check($sformatf("v%0d_wr_cnt", k), wr_cnt - w0, tbl[k].exp_wr);
         check($sformatf("v%0d_no_abort", k), ab_cnt - a0, 0);
         check($sformatf("v%0d_oe", k), oe_err, 0);
      end

      // Write strobe lands exactly on the 16th rising edge.
      w0 = wr_cnt;
      frame(7'h05, 1'b0, 8'h81, 15, -1, 1'b0, rd);
      check("wr_before_16", wr_cnt - w0, 0);
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      check("wr_on_16", bus.wr_strobe, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      check("wr_one_cycle", bus.wr_strobe, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      read_check("rd_05", 7'h05, -1, 8'h81);

      // Asynchronous reset mid-write; miso is 1 left over from the previous read.
      frame(7'h33, 1'b0, 8'h5A, 12, -1, 1'b0, rd);
      #3 reset_n = 1'b0;
      #1 check("rst_mid_outs", {bus.miso, bus.miso_oe, bus.wr_strobe, bus.frame_abort}, 4'h0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      reset_n = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      read_check("rd_33_after_rst", 7'h33, -1, 8'h00);
      read_check("rd_15_cleared", 7'h15, -1, 8'h00);

      // CS raised after 5 data bits of a write.
      w0 = wr_cnt;
      a0 = ab_cnt;
      frame(7'h7F, 1'b0, 8'hC3, 13, -1, 1'b0, rd);
      exp_oe = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      check("abort_pulse", bus.frame_abort, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      check("abort_one_cycle", bus.frame_abort, 1'b0);
      check("abort_cnt", ab_cnt - a0, 1);
      check("abort_no_wr", wr_cnt - w0, 0);
      read_check("rd_7f_after_abort", 7'h7F, -1, 8'h00);

      // Edge collisions: during ADDR (write) and during READ.
      w0 = wr_cnt;
      frame(7'h2A, 1'b0, 8'h96, 16, 3, 1'b1, rd);
      check("collide_wr_cnt", wr_cnt - w0, 1);
      read_check("rd_2a_collide", 7'h2A, 9, 8'h96);
      read_check("rd_2a_clean", 7'h2A, -1, 8'h96);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
